alarm_arm_controller: RTL and testbench

ALARM_ARM_CONTROLLER -- requirements
Module: alarm_arm_controller

---
 rtl/alarm_arm_controller.sv | 170 +++++++++++++++++
 tb/tb_alarm_arm_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alarm_arm_controller.sv
// Arm/disarm sequencer for the burglar_alarm block: exit/entry delays, siren timing,
// breach capture and a one-cycle clear pulse. All outputs are registered.
module alarm_arm_controller #(
    parameter int EXIT_DLY  = 16,
    parameter int ENTRY_DLY = 8,
    parameter int SIREN_LEN = 32,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       armReq,
    input  logic       disarmReq,
    input  logic       garageSel,
    input  logic [7:0] alarmEnable,
    input  logic       garageAlarm,
    output logic       homeLocked,
    output logic       garageLocked,
    output logic       alarmClear,
    output logic       siren,
    output logic       chime,
    output logic       breachValid,
    output logic [3:0] breachZone,
    output logic [2:0] state
);

    // state     | meaning
    // DISARMED  | idle, doors unlocked, waiting for armReq
    // EXIT      | exit delay running, chime on
    // ARMED     | locked, watching for breaches
    // ENTRY     | entry delay after a door/window breach, chime on
    // ALARM     | siren on for SIREN_LEN cycles, then back to ARMED
    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DLY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gsel_q, gsel_d;
    logic             bv_d;
    logic [3:0]       bz_d;
    logic             clr_d;
    logic             home_d, garage_d, siren_d, chime_d;
    logic [2:0]       low_idx;

    // Lowest set door/window bit wins: scan downward so the last hit is the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (alarmEnable[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gsel_d  = gsel_q;
        bv_d    = breachValid;
        bz_d    = breachZone;
        clr_d   = 1'b0;

        case (state_q)
            S_DISARMED: begin
                if (armReq && !disarmReq) begin
                    state_d = S_EXIT;
                    gsel_d  = garageSel;
                    cnt_d   = EXIT_LOAD;
                    bv_d    = 1'b0;
                    bz_d    = 4'd0;
                end
            end
            S_EXIT: begin
                if (disarmReq) begin
                    state_d = S_DISARMED;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_ARMED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ARMED: begin
                if (disarmReq) begin
                    state_d = S_DISARMED;
                    cnt_d   = '0;
                    clr_d   = 1'b1;
                end else if (garageAlarm) begin
                    state_d = S_ALARM;
                    cnt_d   = SIREN_LOAD;
                    bv_d    = 1'b1;
                    bz_d    = 4'b1000;
                end else if (alarmEnable != 8'd0) begin
                    state_d = S_ENTRY;
                    cnt_d   = ENTRY_LOAD;
                    bv_d    = 1'b1;
                    bz_d    = {1'b0, low_idx};
                end
            end
            S_ENTRY: begin
                if (disarmReq) begin
                    state_d = S_DISARMED;
                    cnt_d   = '0;
                    clr_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_ALARM;
                    cnt_d   = SIREN_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ALARM: begin
                if (disarmReq) begin
                    state_d = S_DISARMED;
                    cnt_d   = '0;
                    clr_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_ARMED;
                    clr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_DISARMED;
                cnt_d   = '0;
            end
        endcase

        home_d   = (state_d == S_ARMED) || (state_d == S_ENTRY) || (state_d == S_ALARM);
        garage_d = home_d && gsel_d;
        chime_d  = (state_d == S_EXIT) || (state_d == S_ENTRY);
        siren_d  = (state_d == S_ALARM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_DISARMED;
            cnt_q        <= '0;
            gsel_q       <= 1'b0;
            homeLocked   <= 1'b0;
            garageLocked <= 1'b0;
            alarmClear   <= 1'b0;
            siren        <= 1'b0;
            chime        <= 1'b0;
            breachValid  <= 1'b0;
            breachZone   <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gsel_q       <= gsel_d;
            homeLocked   <= home_d;
            garageLocked <= garage_d;
            alarmClear   <= clr_d;
            siren        <= siren_d;
            chime        <= chime_d;
            breachValid  <= bv_d;
            breachZone   <= bz_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Bench for alarm_arm_controller: vector table applied through a scoreboard queue,
// plus a hand-written reset-during-siren sequence.
module tb_alarm_arm_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       armReq, disarmReq, garageSel, garageAlarm;
    logic [7:0] alarmEnable;
    logic       homeLocked, garageLocked, alarmClear, siren, chime, breachValid;
    logic [3:0] breachZone;
    logic [2:0] state;

    alarm_arm_controller dut (
        .clk(clk), .reset_n(reset_n), .armReq(armReq), .disarmReq(disarmReq),
        .garageSel(garageSel), .alarmEnable(alarmEnable), .garageAlarm(garageAlarm),
        .homeLocked(homeLocked), .garageLocked(garageLocked), .alarmClear(alarmClear),
        .siren(siren), .chime(chime), .breachValid(breachValid),
        .breachZone(breachZone), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       arm, dis, gsel;
        logic [7:0] en;
        logic       gar;
        logic [15:0] n;
        logic [2:0] st;
        logic       hl, gl, clr, sir, chm, bv;
        logic [3:0] bz;
    } vec_t;

    localparam int NV = 29;
    vec_t        tbl [NV];
    logic [12:0] exp_q [$];
    string       lbl_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // expected pack: {state, homeLocked, garageLocked, alarmClear, siren, chime, breachValid, breachZone}
    wire [12:0] actual = {state, homeLocked, garageLocked, alarmClear, siren, chime,
                          breachValid, breachZone};

    function automatic vec_t mkv(logic a, logic d, logic g, logic [7:0] en, logic gar, int n,
                                 logic [2:0] st, logic hl, logic gl, logic clr, logic sir,
                                 logic chm, logic bv, logic [3:0] bz);
        vec_t v;
        v.arm = a; v.dis = d; v.gsel = g; v.en = en; v.gar = gar; v.n = 16'(n);
        v.st = st; v.hl = hl; v.gl = gl; v.clr = clr; v.sir = sir; v.chm = chm;
        v.bv = bv; v.bz = bz;
        return v;
    endfunction

    function automatic logic [12:0] ex(logic [2:0] st, logic hl, logic gl, logic clr,
                                       logic sir, logic chm, logic bv, logic [3:0] bz);
        return {st, hl, gl, clr, sir, chm, bv, bz};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic a, input logic d, input logic g, input logic [7:0] en,
                        input logic gar, input logic [12:0] expv, input string lbl);
        @(posedge clk);
        #2;
        armReq = a; disarmReq = d; garageSel = g; alarmEnable = en; garageAlarm = gar;
        exp_q.push_back(expv);
        lbl_q.push_back(lbl);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check(lbl_q.pop_front(), actual, exp_q.pop_front());
    end

    initial begin
        reset_n = 1'b0;
        armReq = 0; disarmReq = 0; garageSel = 0; alarmEnable = 8'h00; garageAlarm = 0;

        //                  a d g en     gar  n   st hl gl clr sir chm bv bz
        tbl[0]  = mkv(0,0,0,8'h00,0, 2, 0,0,0,0,0,0,0,4'h0);
        tbl[1]  = mkv(1,1,0,8'h00,0, 1, 0,0,0,0,0,0,0,4'h0);
        tbl[2]  = mkv(1,0,1,8'h00,0, 1, 1,0,0,0,0,1,0,4'h0);
        tbl[3]  = mkv(0,0,0,8'h00,0,15, 1,0,0,0,0,1,0,4'h0);
        tbl[4]  = mkv(0,0,0,8'h00,0, 1, 2,1,1,0,0,0,0,4'h0);
        tbl[5]  = mkv(1,0,0,8'h00,0, 2, 2,1,1,0,0,0,0,4'h0);
        tbl[6]  = mkv(0,0,0,8'h24,0, 1, 3,1,1,0,0,1,1,4'h2);
        tbl[7]  = mkv(0,0,0,8'h01,0, 7, 3,1,1,0,0,1,1,4'h2);
        tbl[8]  = mkv(0,0,0,8'h00,0,32, 4,1,1,0,1,0,1,4'h2);
        tbl[9]  = mkv(0,0,0,8'h00,0, 1, 2,1,1,1,0,0,1,4'h2);
        tbl[10] = mkv(0,0,0,8'h00,0, 1, 2,1,1,0,0,0,1,4'h2);
        tbl[11] = mkv(0,0,0,8'h80,0, 1, 3,1,1,0,0,1,1,4'h7);
        tbl[12] = mkv(0,0,0,8'h00,0, 2, 3,1,1,0,0,1,1,4'h7);
        tbl[13] = mkv(0,1,0,8'h00,0, 1, 0,0,0,1,0,0,1,4'h7);
        tbl[14] = mkv(0,0,0,8'h00,0, 1, 0,0,0,0,0,0,1,4'h7);
        tbl[15] = mkv(1,0,0,8'h00,0, 1, 1,0,0,0,0,1,0,4'h0);
        tbl[16] = mkv(0,0,0,8'h00,0,15, 1,0,0,0,0,1,0,4'h0);
        tbl[17] = mkv(0,0,0,8'h00,0, 1, 2,1,0,0,0,0,0,4'h0);
        tbl[18] = mkv(0,0,0,8'h01,1, 1, 4,1,0,0,1,0,1,4'h8);
        tbl[19] = mkv(0,1,0,8'h00,0, 1, 0,0,0,1,0,0,1,4'h8);
        tbl[20] = mkv(1,0,0,8'h00,0, 1, 1,0,0,0,0,1,0,4'h0);
        tbl[21] = mkv(0,0,0,8'h00,0, 3, 1,0,0,0,0,1,0,4'h0);
        tbl[22] = mkv(0,1,0,8'h00,0, 1, 0,0,0,0,0,0,0,4'h0);
        tbl[23] = mkv(0,0,0,8'h00,0, 1, 0,0,0,0,0,0,0,4'h0);
        tbl[24] = mkv(1,0,1,8'h00,0, 1, 1,0,0,0,0,1,0,4'h0);
        tbl[25] = mkv(0,0,0,8'h00,0,15, 1,0,0,0,0,1,0,4'h0);
        tbl[26] = mkv(0,0,0,8'h00,0, 1, 2,1,1,0,0,0,0,4'h0);
        tbl[27] = mkv(0,1,0,8'h00,0, 1, 0,0,0,1,0,0,0,4'h0);
        tbl[28] = mkv(0,0,0,8'h00,0, 1, 0,0,0,0,0,0,0,4'h0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", actual, 13'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < int'(tbl[i].n); k++) begin
                step(tbl[i].arm, tbl[i].dis, tbl[i].gsel, tbl[i].en, tbl[i].gar,
                     {tbl[i].st, tbl[i].hl, tbl[i].gl, tbl[i].clr, tbl[i].sir,
                      tbl[i].chm, tbl[i].bv, tbl[i].bz},
                     $sformatf("vec%0d_c%0d", i, k));
            end
        end

        // Reset asserted on the tenth siren cycle.
        step(1, 0, 1, 8'h00, 0, ex(1,0,0,0,0,1,0,4'h0), "rs_arm");
        for (int k = 0; k < 15; k++) step(0, 0, 0, 8'h00, 0, ex(1,0,0,0,0,1,0,4'h0), "rs_exit");
        step(0, 0, 0, 8'h00, 0, ex(2,1,1,0,0,0,0,4'h0), "rs_armed");
        step(0, 0, 0, 8'h00, 1, ex(4,1,1,0,1,0,1,4'h8), "rs_siren1");
        for (int k = 0; k < 9; k++) step(0, 0, 0, 8'h00, 0, ex(4,1,1,0,1,0,1,4'h8), "rs_siren");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rs_async_clear", actual, 13'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 8'h00, 0, ex(0,0,0,0,0,0,0,4'h0), "rs_after");

        repeat (2) @(posedge clk);
        #3;
        check("drain", 13'(exp_q.size()), 13'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
